// File: rtl/part_mux_scan_pkg.sv
// Shared definitions for the registered multi-channel selector with scan counter.
// Holds mode encodings, the packed-data slice helper and the parameter legality check.
package part_mux_scan_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // LSB position of channel ch, input idx inside the packed D bus.
    function automatic int d_lsb(input int ch, input int idx, input int nin, input int w);
        return ((ch * nin) + idx) * w;
    endfunction

    function automatic logic params_legal(input int nin, input int sw);
        return (nin >= 32'sd2) && ((32'sd1 << sw) >= nin);
    endfunction

endpackage

// File: rtl/part_mux_scan_ctr.sv
// Round-robin scan counter over 0..NIN-1 with synchronous load, advance and a
// registered one-cycle wrap pulse.
module part_mux_scan_ctr
    import part_mux_scan_pkg::*;
#(
    parameter int NIN = 4,
    parameter int SW  = 2
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          ld_i,
    input  logic [SW-1:0] ld_val_i,
    input  logic          adv_i,
    output logic [SW-1:0] cnt_o,
    output logic          wrap_o
);

    localparam logic [SW:0]   NIN_W = (SW + 1)'(NIN);
    localparam logic [SW-1:0] LAST  = SW'(NIN - 1);

    logic [SW-1:0] cnt_q, cnt_d;
    logic          wrap_q, wrap_d;

    // Next-state: load beats advance; an out-of-range load value restarts at zero.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (ld_i) begin
            if ({1'b0, ld_val_i} < NIN_W) begin
                cnt_d = ld_val_i;
            end else begin
                cnt_d = '0;
            end
        end else if (adv_i) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_q + SW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter and wrap state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = wrap_q;

endmodule

// File: rtl/part_mux_scan.sv
// NCH-channel, NIN-to-1 registered word selector with direct or scan-counter
// selection, per-channel active-low enables and valid flags.
module part_mux_scan
    import part_mux_scan_pkg::*;
#(
    parameter int NCH = 2,
    parameter int NIN = 4,
    parameter int W   = 1,
    parameter int SW  = 2
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [NCH*NIN*W-1:0]   D,
    input  logic [SW-1:0]          S,
    input  logic                   MODE,
    input  logic                   LD,
    input  logic [SW-1:0]          LD_VAL,
    input  logic                   ADV,
    input  logic [NCH-1:0]         E_N,
    output logic [NCH*W-1:0]       Y,
    output logic [NCH-1:0]         Y_VLD,
    output logic [SW-1:0]          SEL_Q,
    output logic [SW-1:0]          CNT,
    output logic                   WRAP
);

    localparam logic [SW:0] NIN_W = (SW + 1)'(NIN);

    if (!params_legal(NIN, SW)) begin : g_param_check
        $error("part_mux_scan: need NIN >= 2 and 2**SW >= NIN");
    end

    logic [SW-1:0] cnt_s;
    logic [SW-1:0] sel_s;
    logic          sel_ok_s;
    logic [SW-1:0] sel_q;

    part_mux_scan_ctr #(
        .NIN (NIN),
        .SW  (SW)
    ) u_ctr (
        .clk_i    (CLK),
        .rst_n_i  (RST_N),
        .ld_i     (LD),
        .ld_val_i (LD_VAL),
        .adv_i    (ADV),
        .cnt_o    (cnt_s),
        .wrap_o   (WRAP)
    );

    // Pre-edge counter value drives the capture, so scan output trails CNT by one edge.
    assign sel_s    = (MODE == MODE_SCAN) ? cnt_s : S;
    assign sel_ok_s = ({1'b0, sel_s} < NIN_W);

    // Selected-index register shared by all channels.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_s;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [W-1:0] y_q, y_d;
        logic         vld_q, vld_d;

        // Disabled or out-of-range selection forces the word low and invalid.
        always_comb begin
            y_d   = '0;
            vld_d = 1'b0;
            if (!E_N[c] && sel_ok_s) begin
                y_d   = D[d_lsb(c, int'(sel_s), NIN, W) +: W];
                vld_d = 1'b1;
            end else begin
                y_d   = '0;
                vld_d = 1'b0;
            end
        end

        // Per-channel output register.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                y_q   <= '0;
                vld_q <= 1'b0;
            end else begin
                y_q   <= y_d;
                vld_q <= vld_d;
            end
        end

        assign Y[c*W +: W] = y_q;
        assign Y_VLD[c]    = vld_q;
    end

    assign SEL_Q = sel_q;
    assign CNT   = cnt_s;

endmodule
